matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: square matrix dimension, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: signed element width.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin a multiply; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: when high, cancels the operation in progress.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-009 SHALL have port rd_en, output, 1 bit: operand read strobe.
REQ-010 SHALL have ports a_addr and b_addr, outputs, clog2(N*N) bits each: row-major operand addresses.
REQ-011 SHALL have ports a_data and b_data, inputs, DATA_W bits each: operand data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port c_we, output, 1 bit: result write strobe.
REQ-013 SHALL have port c_addr, output, clog2(N*N) bits: result address.
REQ-014 SHALL have port c_wdata, output, DATA_W bits: result data.

Function
REQ-015 SHALL implement the states IDLE, RUN, DRAIN, WRITE and DONE.
REQ-016 In IDLE with start=1, SHALL clear i, j, k and acc to 0 and enter RUN on the next cycle.
REQ-017 In RUN, SHALL drive rd_en=1, a_addr=i*N+k and b_addr=k*N+j, and SHALL increment k; after issuing k=N-1 it SHALL enter DRAIN.
REQ-018 SHALL register a valid flag one cycle behind rd_en; while the flag is high, acc SHALL take acc + a_data*b_data (signed product).
REQ-019 DRAIN SHALL last 1 cycle, absorb the last product, and then enter WRITE.
REQ-020 WRITE SHALL last 1 cycle with c_we=1, c_addr=i*N+j and c_wdata=acc reduced to DATA_W per REQ-030, then clear acc and k.
REQ-021 After WRITE, SHALL advance j, wrapping j from N-1 to 0 and incrementing i; it SHALL enter DONE after (i,j)=(N-1,N-1), otherwise RUN.
REQ-022 DONE SHALL assert done=1 for exactly 1 cycle and then return to IDLE.
REQ-023 Each element SHALL take N+2 cycles; if start is sampled at cycle 0, done SHALL be high at cycle N*N*(N+2)+1.
REQ-024 The accumulator width SHALL be 2*DATA_W+clog2(N) bits, signed; it SHALL NOT overflow internally.
REQ-025 start while busy SHALL be ignored, with no state change.
REQ-026 abort in any non-IDLE state SHALL enter IDLE on the next cycle, with no further c_we and no done; abort SHALL take priority over every other transition, including the same cycle as WRITE.
REQ-027 rd_en, c_we and done SHALL be low outside RUN, WRITE and DONE respectively.

Reset
REQ-028 ARESET=1 SHALL, at the next edge, force IDLE, i=j=k=0, acc=0, valid=0 and all outputs 0; it SHALL override start and abort.
REQ-029 Reset asserted mid-operation SHALL discard partial results; after release, the block SHALL accept a new start normally.

Configuration
REQ-030 With macro MATMUL_SEQ_SAT_EN defined, c_wdata SHALL saturate acc to the signed DATA_W range (0x7FFFFFFF / 0x80000000 for DATA_W=32); without it, c_wdata SHALL be the low DATA_W bits of acc.

Structure
REQ-031 Package matmul_pkg SHALL hold the state enum, the clog2-derived index and address width constants, and the accumulator width function.
REQ-032 SHALL instantiate one sub-module, matmul_mac (registered signed multiply-accumulate with clear), inside the sequencer.

Verification
REQ-033 Scenario: N=2, A=identity, B={1,2,3,4} -> writes to c_addr 0..3 carry 1,2,3,4 in order, and done at cycle 17.
REQ-034 Scenario: N=4, all A and B elements = 1 -> 16 writes of 4, and done at cycle 97.
REQ-035 Scenario: N=2, A={-1,2,3,-4}, B={5,6,7,8} -> C={9,10,-13,-14}.
REQ-036 Scenario: start pulsed at cycles 3 and 10 during the REQ-033 run -> unchanged results and a single done.
REQ-037 Scenario: abort at cycle 6 of the REQ-033 run -> exactly one write (c_addr 0 = 1), no done, busy low at cycle 7; ARESET mid-run -> all outputs 0 on the next cycle.
REQ-038 Scenario: N=2, A row 0 and B column 0 all 0x7FFFFFFF -> C[0] = 0x00000002 without MATMUL_SEQ_SAT_EN and 0x7FFFFFFF with it.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared state encoding and sizing helpers for the matrix-multiply sequencer.
// Build option: define MATMUL_SEQ_SAT_EN to saturate written results.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_IDX_W  = $clog2(DEF_N);
    localparam int DEF_ADDR_W = $clog2(DEF_N * DEF_N);

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_width(input int n);
        return $clog2(n * n);
    endfunction

    // Wide enough for N full-scale signed products without wrapping.
    function automatic int acc_width(input int n, input int data_w);
        return 2 * data_w + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Registered signed multiply-accumulate; clear wins over accumulate.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = acc_width(DEF_N, DEF_DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    acc_q;

    always_comb begin
        // Sign-extend both operands so the low 2*DATA_W bits hold the signed product.
        prod  = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences C = A * B one element at a time: N operand reads, a drain cycle, one write.
// Build option: define MATMUL_SEQ_SAT_EN to saturate c_wdata instead of truncating.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [$clog2(N*N)-1:0]  a_addr,
    output logic [$clog2(N*N)-1:0]  b_addr,
    input  logic [DATA_W-1:0]       a_data,
    input  logic [DATA_W-1:0]       b_data,
    output logic                    c_we,
    output logic [$clog2(N*N)-1:0]  c_addr,
    output logic [DATA_W-1:0]       c_wdata,
    output logic [2:0]              dbg_state
);

    localparam int IDX_W  = idx_width(N);
    localparam int ADDR_W = addr_width(N);
    localparam int ACC_W  = acc_width(N, DATA_W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    state_t            state_d, state_q;
    logic [IDX_W-1:0]  i_d, i_q, j_d, j_q, k_d, k_q;
    logic              busy_d, busy_q, done_d, done_q;
    logic              rd_en_d, rd_en_q, c_we_d, c_we_q, valid_d, valid_q;
    logic [ADDR_W-1:0] a_addr_d, a_addr_q, b_addr_d, b_addr_q, c_addr_d, c_addr_q;
    logic              acc_clr;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] wdata;

    function automatic logic [ADDR_W-1:0] lin(input logic [IDX_W-1:0] r,
                                              input logic [IDX_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(N) + ADDR_W'(c);
    endfunction

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        valid_d  = rd_en_q;
        acc_clr  = 1'b0;
        a_addr_d = '0;
        b_addr_d = '0;
        c_addr_d = '0;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            valid_d = 1'b0;
            acc_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        acc_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (k_q == LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        k_d = k_q + ONE;
                    end
                end
                ST_DRAIN: state_d = ST_WRITE;
                ST_WRITE: begin
                    acc_clr = 1'b1;
                    k_d     = '0;
                    state_d = ST_RUN;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            i_d = i_q + ONE;
                        end
                    end else begin
                        j_d = j_q + ONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        // Outputs are registered, so they are derived from the state being entered.
        busy_d  = (state_d != ST_IDLE);
        rd_en_d = (state_d == ST_RUN);
        c_we_d  = (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
        if (rd_en_d) begin
            a_addr_d = lin(i_d, k_d);
            b_addr_d = lin(k_d, j_d);
        end
        if (c_we_d) begin
            c_addr_d = lin(i_d, j_d);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= ST_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            c_we_q   <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            c_we_q   <= c_we_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            c_addr_q <= c_addr_d;
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk (ACLK),
        .rst (ARESET),
        .clr (acc_clr),
        .en  (valid_q),
        .a   (a_data),
        .b   (b_data),
        .acc (acc)
    );

`ifdef MATMUL_SEQ_SAT_EN
    logic [ACC_W-DATA_W:0] acc_top;

    // The value fits when every bit from the DATA_W sign position upward agrees.
    always_comb begin
        acc_top = acc[ACC_W-1:DATA_W-1];
        if (acc_top == '0 || acc_top == '1) begin
            wdata = acc[DATA_W-1:0];
        end else if (acc[ACC_W-1]) begin
            wdata = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            wdata = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    logic [ACC_W-DATA_W-1:0] acc_unused;

    assign acc_unused = acc[ACC_W-1:DATA_W];
    assign wdata      = acc[DATA_W-1:0];
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign a_addr    = a_addr_q;
    assign b_addr    = b_addr_q;
    assign c_we      = c_we_q;
    assign c_addr    = c_addr_q;
    assign c_wdata   = c_we_q ? wdata : '0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: an N=2 instance for most scenarios, an N=4 instance for the all-ones run.
module tb_matmul_sequencer;

    localparam int DW = 32;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // N=2 instance
    logic          start2 = 1'b0, abort2 = 1'b0;
    logic          busy2, done2, rd_en2, c_we2;
    logic [1:0]    a_addr2, b_addr2, c_addr2;
    logic [DW-1:0] a_data2 = '0, b_data2 = '0, c_wdata2;
    logic [2:0]    st2;
    logic [DW-1:0] a_mem2 [4];
    logic [DW-1:0] b_mem2 [4];

    // N=4 instance
    logic          start4 = 1'b0, abort4 = 1'b0;
    logic          busy4, done4, rd_en4, c_we4;
    logic [3:0]    a_addr4, b_addr4, c_addr4;
    logic [DW-1:0] a_data4 = '0, b_data4 = '0, c_wdata4;
    logic [2:0]    st4;
    logic [DW-1:0] a_mem4 [16];
    logic [DW-1:0] b_mem4 [16];

    matmul_sequencer #(.N(2), .DATA_W(DW)) dut2 (
        .ACLK(ACLK), .ARESET(ARESET), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .rd_en(rd_en2),
        .a_addr(a_addr2), .b_addr(b_addr2), .a_data(a_data2), .b_data(b_data2),
        .c_we(c_we2), .c_addr(c_addr2), .c_wdata(c_wdata2), .dbg_state(st2)
    );

    matmul_sequencer #(.N(4), .DATA_W(DW)) dut4 (
        .ACLK(ACLK), .ARESET(ARESET), .start(start4), .abort(abort4),
        .busy(busy4), .done(done4), .rd_en(rd_en4),
        .a_addr(a_addr4), .b_addr(b_addr4), .a_data(a_data4), .b_data(b_data4),
        .c_we(c_we4), .c_addr(c_addr4), .c_wdata(c_wdata4), .dbg_state(st4)
    );

    // Operand memories: data one cycle after rd_en, garbage otherwise.
    always @(posedge ACLK) begin
        a_data2 <= rd_en2 ? a_mem2[a_addr2] : 32'hDEAD_BEEF;
        b_data2 <= rd_en2 ? b_mem2[b_addr2] : 32'hBAD0_F00D;
        a_data4 <= rd_en4 ? a_mem4[a_addr4] : 32'hDEAD_BEEF;
        b_data4 <= rd_en4 ? b_mem4[b_addr4] : 32'hBAD0_F00D;
    end

    // Scoreboard: {addr[3:0], data[31:0]} per expected write, plus expected done cycles.
    logic [35:0] exp2_q[$];
    logic [35:0] exp4_q[$];
    int          done2_q[$];
    int          done4_q[$];
    int          t0_2 = 0;
    int          t0_4 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h, required nothing", name, act);
    endtask

    always @(negedge ACLK) begin
        if (c_we2) begin
            if (exp2_q.size() == 0) report_fail("dut2_unexpected_write", {c_addr2, c_wdata2});
            else check("dut2_write", {4'(c_addr2), c_wdata2}, exp2_q.pop_front());
        end
        if (done2) begin
            if (done2_q.size() == 0) report_fail("dut2_unexpected_done", 64'(cyc - t0_2));
            else check("dut2_done_cycle", 64'(cyc - t0_2), 64'(done2_q.pop_front()));
        end
        if (c_we4) begin
            if (exp4_q.size() == 0) report_fail("dut4_unexpected_write", {c_addr4, c_wdata4});
            else check("dut4_write", {c_addr4, c_wdata4}, exp4_q.pop_front());
        end
        if (done4) begin
            if (done4_q.size() == 0) report_fail("dut4_unexpected_done", 64'(cyc - t0_4));
            else check("dut4_done_cycle", 64'(cyc - t0_4), 64'(done4_q.pop_front()));
        end
    end

    task automatic load2(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
        a_mem2[0] = a0; a_mem2[1] = a1; a_mem2[2] = a2; a_mem2[3] = a3;
        b_mem2[0] = b0; b_mem2[1] = b1; b_mem2[2] = b2; b_mem2[3] = b3;
    endtask

    task automatic exp_w2(input int addr, input logic [31:0] data);
        exp2_q.push_back({4'(addr), data});
    endtask

    task automatic check_outputs_zero2(input string tag);
        check({tag, "_busy"},    busy2,    0);
        check({tag, "_done"},    done2,    0);
        check({tag, "_rd_en"},   rd_en2,   0);
        check({tag, "_c_we"},    c_we2,    0);
        check({tag, "_a_addr"},  a_addr2,  0);
        check({tag, "_b_addr"},  b_addr2,  0);
        check({tag, "_c_addr"},  c_addr2,  0);
        check({tag, "_c_wdata"}, c_wdata2, 0);
        check({tag, "_state"},   st2,      0);
    endtask

    // Cycle 0 is the cycle in which start is high; the other pulses land at the given cycles (-1 = none).
    task automatic run2(input int start_a, input int start_b, input int abort_c, input int reset_c);
        int rel;
        bit fin;
        @(negedge ACLK);
        start2 = 1'b1;
        t0_2   = cyc;
        fin    = 1'b0;
        while (!fin) begin
            @(negedge ACLK);
            rel    = cyc - t0_2;
            start2 = (rel == start_a) || (rel == start_b);
            abort2 = (rel == abort_c);
            ARESET = (rel == reset_c);
            if (rel == abort_c + 1) check("abort_busy_low", busy2, 0);
            if (rel == reset_c + 1) check_outputs_zero2("midrun_reset");
            if (!busy2) begin
                fin = 1'b1;
            end else if (rel > 200) begin
                report_fail("dut2_timeout", 64'(rel));
                fin = 1'b1;
            end
        end
        start2 = 1'b0;
        abort2 = 1'b0;
        ARESET = 1'b0;
        repeat (4) @(negedge ACLK);
    endtask

    task automatic end_check2(input string tag);
        check({tag, "_writes_left"}, exp2_q.size(), 0);
        check({tag, "_done_left"},   done2_q.size(), 0);
        exp2_q.delete();
        done2_q.delete();
    endtask

    task automatic run4();
        int rel;
        bit fin;
        @(negedge ACLK);
        start4 = 1'b1;
        t0_4   = cyc;
        fin    = 1'b0;
        while (!fin) begin
            @(negedge ACLK);
            start4 = 1'b0;
            rel    = cyc - t0_4;
            if (!busy4) begin
                fin = 1'b1;
            end else if (rel > 300) begin
                report_fail("dut4_timeout", 64'(rel));
                fin = 1'b1;
            end
        end
        repeat (4) @(negedge ACLK);
    endtask

    task automatic load_identity_run();
        load2(1, 0, 0, 1, 1, 2, 3, 4);
    endtask

    initial begin
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        check_outputs_zero2("reset2");
        check("reset4_busy", busy4, 0);
        check("reset4_done", done4, 0);
        check("reset4_c_we", c_we4, 0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Identity times {1,2,3,4}
        load_identity_run();
        exp_w2(0, 1); exp_w2(1, 2); exp_w2(2, 3); exp_w2(3, 4);
        done2_q.push_back(17);
        run2(-1, -1, -1, -1);
        end_check2("identity");

        // Signed operands
        load2(-1, 2, 3, -4, 5, 6, 7, 8);
        exp_w2(0, 9); exp_w2(1, 10); exp_w2(2, -13); exp_w2(3, -14);
        done2_q.push_back(17);
        run2(-1, -1, -1, -1);
        end_check2("signed");

        // Start pulses while busy are ignored
        load_identity_run();
        exp_w2(0, 1); exp_w2(1, 2); exp_w2(2, 3); exp_w2(3, 4);
        done2_q.push_back(17);
        run2(3, 10, -1, -1);
        end_check2("start_busy");

        // Abort after the first write
        load_identity_run();
        exp_w2(0, 1);
        run2(-1, -1, 6, -1);
        end_check2("abort");

        // Reset mid-run, then a normal run
        load_identity_run();
        exp_w2(0, 1);
        run2(-1, -1, -1, 6);
        end_check2("reset_mid");
        exp_w2(0, 1); exp_w2(1, 2); exp_w2(2, 3); exp_w2(3, 4);
        done2_q.push_back(17);
        run2(-1, -1, -1, -1);
        end_check2("after_reset");

        // Positive overflow of C[0]: 2 * 0x7FFFFFFF^2
        load2(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0);
`ifdef MATMUL_SEQ_SAT_EN
        exp_w2(0, 32'h7FFF_FFFF);
`else
        exp_w2(0, 32'h0000_0002);
`endif
        exp_w2(1, 0); exp_w2(2, 0); exp_w2(3, 0);
        done2_q.push_back(17);
        run2(-1, -1, -1, -1);
        end_check2("sat_pos");

        // Negative overflow of C[0]: 2 * (-2^31) * (2^31-1) = -(2^63 - 2^32)
        load2(32'h8000_0000, 32'h8000_0000, 0, 0, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0);
`ifdef MATMUL_SEQ_SAT_EN
        exp_w2(0, 32'h8000_0000);
`else
        exp_w2(0, 32'h0000_0000);
`endif
        exp_w2(1, 0); exp_w2(2, 0); exp_w2(3, 0);
        done2_q.push_back(17);
        run2(-1, -1, -1, -1);
        end_check2("sat_neg");

        // N=4 all ones: sixteen writes of 4, done at 16*6+1
        for (int n = 0; n < 16; n++) begin
            a_mem4[n] = 1;
            b_mem4[n] = 1;
            exp4_q.push_back({4'(n), 32'd4});
        end
        done4_q.push_back(97);
        run4();
        check("ones4_writes_left", exp4_q.size(), 0);
        check("ones4_done_left",   done4_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
